// File: rtl/fft_unload_pkg.sv
// Shared types, defaults and helpers for the FFT result-buffer unload path.
package fft_unload_pkg;

  localparam int unsigned DFLT_ADDR_W     = 8;
  localparam int unsigned DFLT_DATA_W     = 32;
  localparam int unsigned DFLT_RD_LAT     = 2;
  localparam int unsigned DFLT_FIFO_DEPTH = 4;
  localparam int unsigned FRAME_LEN       = 2 ** DFLT_ADDR_W;
  localparam int unsigned CNT_W           = $clog2(DFLT_FIFO_DEPTH + 1);
  localparam int unsigned MAX_ADDR_W      = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_e;

  // Reverse the low w bits of a; upper bits are returned as zero.
  function automatic logic [MAX_ADDR_W-1:0] bit_reverse(input logic [MAX_ADDR_W-1:0] a,
                                                        input int unsigned w);
    logic [MAX_ADDR_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < w; i++) begin
      r[i] = a[w-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/adc_fft_if_unload_fifo.sv
// Shift-register FIFO whose head entry is always slot 0, so head outputs come straight from flops.
module adc_fft_if_unload_fifo
  import fft_unload_pkg::*;
#(
  parameter int unsigned W     = DFLT_DATA_W + DFLT_ADDR_W + 1,
  parameter int unsigned DEPTH = DFLT_FIFO_DEPTH,
  parameter int unsigned CW    = CNT_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          wr,
  input  logic [W-1:0]  wdata,
  input  logic          rd,
  output logic [W-1:0]  rdata,
  output logic          rvalid,
  output logic [CW-1:0] count
);

  logic [W-1:0]     slot_q [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    wpos_c;

  // A simultaneous pop shifts everything down, so the write lands one slot lower.
  assign wpos_c = count_q - CW'(rd);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        slot_q[i] <= '0;
      end
      vld_q   <= '0;
      count_q <= '0;
    end else if (clr) begin
      vld_q   <= '0;
      count_q <= '0;
    end else begin
      if (rd) begin
        for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
          slot_q[i] <= slot_q[i+1];
          vld_q[i]  <= vld_q[i+1];
        end
        vld_q[DEPTH-1] <= 1'b0;
      end
      if (wr) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (wpos_c == CW'(i)) begin
            slot_q[i] <= wdata;
            vld_q[i]  <= 1'b1;
          end
        end
      end
      count_q <= count_q + CW'(wr) - CW'(rd);
    end
  end

  assign rdata  = slot_q[0];
  assign rvalid = vld_q[0];
  assign count  = count_q;

endmodule

// File: rtl/adc_fft_if_fft_unload.sv
// Sweeps the FFT result buffer read port and streams the frame out with credit-based backpressure.
module adc_fft_if_fft_unload
  import fft_unload_pkg::*;
#(
  parameter int unsigned ADDR_W     = $clog2(FRAME_LEN),
  parameter int unsigned DATA_W     = DFLT_DATA_W,
  parameter int unsigned RD_LAT     = DFLT_RD_LAT,
  parameter int unsigned FIFO_DEPTH = DFLT_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              nGrst,
  input  logic              start,
  input  logic              bitrev,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rAddr,
  output logic              rBlk,
  input  logic [DATA_W-1:0] rD,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [ADDR_W-1:0] m_index,
  output logic              m_last
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned EW = DATA_W + ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_BIN = '1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, idx_q, r_addr_q;
  logic              bitrev_q, r_blk_q, busy_q, done_q;
  logic [CW-1:0]     infl_q, fifo_count;
  logic [RD_LAT-1:0] pipe_vld_q;
  logic [ADDR_W-1:0] pipe_idx_q [RD_LAT];
  logic              clr_c, issue_c, pop_c, wr_c, fifo_valid;
  logic [CW:0]       used_c;
  logic [EW-1:0]     fifo_wdata, fifo_head;

  assign pop_c = fifo_valid & m_ready;
  assign wr_c  = pipe_vld_q[RD_LAT-1];
  // The beat leaving this cycle frees its slot now, which keeps a full-rate stream bubble-free.
  assign used_c = (CW+1)'(fifo_count) + (CW+1)'(infl_q) - (CW+1)'(pop_c);

  always_comb begin
    state_d = state_q;
    clr_c   = 1'b0;
    issue_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          clr_c   = 1'b1;
        end
      end
      RUN: begin
        issue_c = (used_c < (CW+1)'(FIFO_DEPTH));
        if (issue_c && (cnt_q == LAST_BIN)) state_d = DRAIN;
      end
      DRAIN: begin
        if (pop_c && fifo_head[EW-1]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nGrst) begin
    if (!nGrst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Issue side: read address/enable, issue counter and in-flight credit counter.
  always_ff @(posedge clk or negedge nGrst) begin
    if (!nGrst) begin
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      r_blk_q  <= 1'b0;
      r_addr_q <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      infl_q   <= '0;
      bitrev_q <= 1'b0;
    end else begin
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_q == DRAIN) && (state_d == IDLE);
      r_blk_q <= issue_c;
      if (clr_c) begin
        bitrev_q <= bitrev;
        cnt_q    <= '0;
        infl_q   <= '0;
      end else begin
        if (issue_c) begin
          r_addr_q <= bitrev_q ? ADDR_W'(bit_reverse(MAX_ADDR_W'(cnt_q), ADDR_W)) : cnt_q;
          idx_q    <= cnt_q;
          cnt_q    <= cnt_q + ADDR_W'(1);
        end
        infl_q <= infl_q + CW'(issue_c) - CW'(wr_c);
      end
    end
  end

  // Return pipe: the rBlk/idx register plus RD_LAT stages lines the index up with rD.
  always_ff @(posedge clk or negedge nGrst) begin
    if (!nGrst) begin
      pipe_vld_q <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        pipe_idx_q[i] <= '0;
      end
    end else begin
      pipe_vld_q[0] <= r_blk_q & ~clr_c;
      pipe_idx_q[0] <= idx_q;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1] & ~clr_c;
        pipe_idx_q[i] <= pipe_idx_q[i-1];
      end
    end
  end

  assign fifo_wdata = {(pipe_idx_q[RD_LAT-1] == LAST_BIN), pipe_idx_q[RD_LAT-1], rD};

  adc_fft_if_unload_fifo #(
    .W     (EW),
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (nGrst),
    .clr    (clr_c),
    .wr     (wr_c),
    .wdata  (fifo_wdata),
    .rd     (pop_c),
    .rdata  (fifo_head),
    .rvalid (fifo_valid),
    .count  (fifo_count)
  );

  assign busy    = busy_q;
  assign done    = done_q;
  assign rAddr   = r_addr_q;
  assign rBlk    = r_blk_q;
  assign m_valid = fifo_valid;
  assign m_data  = fifo_head[DATA_W-1:0];
  assign m_index = fifo_head[DATA_W +: ADDR_W];
  assign m_last  = fifo_head[EW-1];

endmodule

// File: tb/tb_adc_fft_if_fft_unload.sv
// Directed bench for the FFT unload controller with a 2-cycle-latency buffer model.
module tb_adc_fft_if_fft_unload;

  logic        clk = 1'b0;
  logic        nGrst = 1'b1;
  logic        start = 1'b0;
  logic        bitrev = 1'b0;
  logic        m_ready = 1'b0;
  logic        busy, done, rBlk, m_valid, m_last;
  logic [7:0]  rAddr, m_index;
  logic [31:0] rD, m_data, ram_s1;
  logic [31:0] mem [256];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  adc_fft_if_fft_unload dut (
    .clk     (clk),
    .nGrst   (nGrst),
    .start   (start),
    .bitrev  (bitrev),
    .busy    (busy),
    .done    (done),
    .rAddr   (rAddr),
    .rBlk    (rBlk),
    .rD      (rD),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_index (m_index),
    .m_last  (m_last)
  );

  // Buffer model: address sampled at the first edge, data out after the second.
  always @(posedge clk) begin
    ram_s1 <= rBlk ? mem[rAddr] : 32'hDEAD_BEEF;
    rD     <= ram_s1;
  end

  function automatic logic [7:0] rev8(input logic [7:0] a);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = a[7-i];
    return r;
  endfunction

  task automatic pulse_start(input logic br);
    @(negedge clk);
    start  = 1'b1;
    bitrev = br;
    @(negedge clk);
    start  = 1'b0;
    bitrev = 1'b0;
  endtask

  task automatic test_reset;
    nGrst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, rBlk, m_valid, m_last, rAddr, m_index, m_data} !== 53'd0) begin
      failures++;
      $display("FAIL reset_state busy=%b done=%b rBlk=%b m_valid=%b m_last=%b rAddr=%h m_index=%h m_data=%h, required all zero",
               busy, done, rBlk, m_valid, m_last, rAddr, m_index, m_data);
    end
    nGrst = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || rBlk !== 1'b0 || m_valid !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset busy=%b rBlk=%b m_valid=%b, required 0 0 0", busy, rBlk, m_valid);
    end
  endtask

  // Full-rate frame: exact read cycles, beat cycles and done cycle relative to start.
  task automatic test_stream(input logic br);
    int beat = 0, rd = 0, dones = 0, done_cyc = -1;
    logic [7:0] ea;
    m_ready = 1'b1;
    pulse_start(br);
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (rBlk) begin
        ea = br ? rev8(8'(rd)) : 8'(rd);
        checks++;
        if (rAddr !== ea || cyc != rd + 1) begin
          failures++;
          $display("FAIL stream_raddr br=%0d read=%0d rAddr=%h at cyc %0d, required %h at cyc %0d",
                   br, rd, rAddr, cyc, ea, rd + 1);
        end
        rd++;
      end
      if (m_valid && m_ready) begin
        ea = br ? rev8(8'(beat)) : 8'(beat);
        checks++;
        if (m_data !== mem[ea] || m_index !== 8'(beat) || m_last !== 1'(beat == 255) || cyc != beat + 4) begin
          failures++;
          $display("FAIL stream_beat br=%0d beat=%0d data=%h idx=%h last=%b cyc=%0d, required %h %h %b cyc %0d",
                   br, beat, m_data, m_index, m_last, cyc, mem[ea], 8'(beat), beat == 255, beat + 4);
        end
        beat++;
      end
      if (done) begin
        dones++;
        done_cyc = cyc;
      end
      @(negedge clk);
    end
    checks++;
    if (beat != 256 || rd != 256 || dones != 1 || done_cyc != 260 || busy !== 1'b0) begin
      failures++;
      $display("FAIL stream_summary br=%0d beats=%0d reads=%0d dones=%0d done_cyc=%0d busy=%b, required 256 256 1 260 0",
               br, beat, rd, dones, done_cyc, busy);
    end
  endtask

  task automatic test_backpressure;
    int beat = 0, issued = 0, dones = 0, maxo = 0;
    logic held = 1'b0;
    logic [40:0] hv = '0;
    m_ready = 1'b0;
    pulse_start(1'b0);
    for (int cyc = 0; cyc < 1500; cyc++) begin
      m_ready = ($urandom_range(0, 9) < 3);
      if (held) begin
        checks++;
        if (m_valid !== 1'b1 || {m_last, m_index, m_data} !== hv) begin
          failures++;
          $display("FAIL bp_stable cyc=%0d valid=%b head=%h, required 1 %h", cyc, m_valid, {m_last, m_index, m_data}, hv);
        end
      end
      if (rBlk) issued++;
      if (issued - beat > maxo) maxo = issued - beat;
      if (m_valid && m_ready) begin
        checks++;
        if (m_data !== mem[8'(beat)] || m_index !== 8'(beat) || m_last !== 1'(beat == 255)) begin
          failures++;
          $display("FAIL bp_beat beat=%0d data=%h idx=%h last=%b, required %h %h %b",
                   beat, m_data, m_index, m_last, mem[8'(beat)], 8'(beat), beat == 255);
        end
        beat++;
      end
      held = m_valid && !m_ready;
      hv   = {m_last, m_index, m_data};
      if (done) dones++;
      @(negedge clk);
    end
    m_ready = 1'b1;
    checks++;
    if (beat != 256 || issued != 256 || dones != 1 || maxo > 4) begin
      failures++;
      $display("FAIL bp_summary beats=%0d reads=%0d dones=%0d max_outstanding=%0d, required 256 256 1 <=4",
               beat, issued, dones, maxo);
    end
  endtask

  task automatic test_long_stall;
    int first = -1, reads = 0, beat = 0, last_hs = -1, dones = 0;
    m_ready = 1'b0;
    pulse_start(1'b0);
    for (int cyc = 0; cyc < 400; cyc++) begin
      m_ready = (first >= 0) && (cyc >= first + 50);
      if (rBlk) reads++;
      if (m_valid && first < 0) first = cyc;
      if (first >= 0 && cyc == first + 49) begin
        checks++;
        if (reads != 4) begin
          failures++;
          $display("FAIL stall_reads reads=%0d after 50 stalled cycles, required 4", reads);
        end
      end
      if (m_valid && m_ready) begin
        checks++;
        if (m_data !== mem[8'(beat)] || m_index !== 8'(beat) || (beat > 0 && cyc != last_hs + 1)) begin
          failures++;
          $display("FAIL stall_resume beat=%0d idx=%h data=%h cyc=%0d, required %h %h cyc %0d",
                   beat, m_index, m_data, cyc, 8'(beat), mem[8'(beat)], last_hs + 1);
        end
        last_hs = cyc;
        beat++;
      end
      if (done) dones++;
      @(negedge clk);
    end
    m_ready = 1'b1;
    checks++;
    if (beat != 256 || reads != 256 || dones != 1 || first != 4) begin
      failures++;
      $display("FAIL stall_summary beats=%0d reads=%0d dones=%0d first_valid=%0d, required 256 256 1 4",
               beat, reads, dones, first);
    end
  endtask

  task automatic test_start_busy;
    int beat = 0, dones = 0, done_cyc = -1;
    m_ready = 1'b1;
    pulse_start(1'b0);
    for (int cyc = 0; cyc < 300; cyc++) begin
      start  = (cyc == 100);
      bitrev = (cyc == 100);
      if (m_valid && m_ready) begin
        checks++;
        if (m_data !== mem[8'(beat)] || m_index !== 8'(beat)) begin
          failures++;
          $display("FAIL busy_beat beat=%0d idx=%h data=%h, required %h %h", beat, m_index, m_data, 8'(beat), mem[8'(beat)]);
        end
        beat++;
      end
      if (done) begin
        dones++;
        done_cyc = cyc;
      end
      @(negedge clk);
    end
    start  = 1'b0;
    bitrev = 1'b0;
    checks++;
    if (beat != 256 || dones != 1 || done_cyc != 260 || busy !== 1'b0) begin
      failures++;
      $display("FAIL busy_summary beats=%0d dones=%0d done_cyc=%0d busy=%b, required 256 1 260 0", beat, dones, done_cyc, busy);
    end
  endtask

  task automatic test_reset_mid;
    int beat = 0;
    m_ready = 1'b1;
    pulse_start(1'b0);
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (m_valid && m_ready) beat++;
      if (beat == 100) break;
      @(negedge clk);
    end
    checks++;
    if (beat != 100) begin
      failures++;
      $display("FAIL reset_mid_reach beats=%0d before timeout, required 100", beat);
    end
    nGrst = 1'b0;
    #1;
    checks++;
    if ({busy, done, rBlk, m_valid, m_last, rAddr, m_index, m_data} !== 53'd0) begin
      failures++;
      $display("FAIL reset_mid_state busy=%b done=%b rBlk=%b m_valid=%b m_last=%b rAddr=%h m_index=%h m_data=%h, required all zero",
               busy, done, rBlk, m_valid, m_last, rAddr, m_index, m_data);
    end
    @(negedge clk);
    nGrst = 1'b1;
    @(negedge clk);
    test_stream(1'b0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'(i) * 32'h0001_0001;
    #1;
    test_reset;
    test_stream(1'b0);
    test_stream(1'b1);
    test_backpressure;
    test_long_stall;
    test_start_busy;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
